telemetry_framer: RTL

//  Parametrised game-state telemetry packetiser feeding the UART byte transmitter.

---
 rtl/telemetry_pkg.sv | 33 +++
 rtl/frame_gap_timer.sv | 37 +++
 rtl/telemetry_framer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_pkg
// Description : Shared types and helpers for the telemetry framer: FSM state
//               encoding, default frame delimiters and the bytes-per-field
//               helper.
//               Optional feature macro: TELEMETRY_CHECKSUM_EN adds the CSUM
//               state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package telemetry_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;
  localparam logic [7:0] DEFAULT_FOOTER = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FIELD = 3'd2,
`ifdef TELEMETRY_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_FTR   = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_per_field(input int field_w);
    return (field_w + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_gap_timer
// Description : Loadable down-counter that stops at zero.
// Ports       : clk   in  system clock
//               rst   in  synchronous active-low reset
//               load  in  load the counter with value (wins over counting)
//               value in  load value, WIDTH bits
//               zero  out counter currently at zero
// Revision    : 1.0 - initial release
// ============================================================================
module frame_gap_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_framer
// Description : Game-state telemetry packetiser. Snapshots NUM_FIELDS fields
//               at frame start and streams HEADER, field bytes (field 0
//               first, MSB byte first), optional checksum, FOOTER over a
//               valid/ready byte interface, with FRAME_GAP idle clocks
//               between frames.
//               Optional feature macro: TELEMETRY_CHECKSUM_EN inserts the XOR
//               of all field bytes just before FOOTER.
// Ports       : clk         in  system clock
//               rst         in  synchronous active-low reset
//               enable      in  stream frames while high
//               fields      in  flat field bus, field i at [i*FIELD_W +: FIELD_W]
//               tx_data     out byte to transmit
//               tx_valid    out tx_data valid
//               tx_ready    in  sink accepts byte
//               frame_done  out 1-cycle pulse on FOOTER acceptance
//               frame_count out completed frames, wrapping
//               busy        out FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         NUM_FIELDS = 8,
  parameter int         FIELD_W    = 8,
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter logic [7:0] FOOTER     = DEFAULT_FOOTER,
  parameter int         FRAME_GAP  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          busy
);

  localparam int BPF       = bytes_per_field(FIELD_W);
  localparam int NUM_BYTES = NUM_FIELDS * BPF;
  localparam int FIDX_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BIDX_W    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int PTR_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_W     = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

  localparam logic [FIDX_W-1:0] LAST_FIELD = FIDX_W'(NUM_FIELDS - 1);
  localparam logic [BIDX_W-1:0] TOP_BYTE   = BIDX_W'(BPF - 1);
  // The GAP state is left on the cycle the counter sits at zero, so loading
  // FRAME_GAP-1 yields exactly FRAME_GAP idle clocks; FRAME_GAP=0 still
  // spends one cycle in GAP.
  localparam logic [GAP_W-1:0]  GAP_LOAD   = (FRAME_GAP > 0) ? GAP_W'(FRAME_GAP - 1) : '0;

  state_t state;
  state_t state_nxt;

  logic [NUM_FIELDS*FIELD_W-1:0] snapshot;
  logic [FIDX_W-1:0]             field_idx;
  logic [BIDX_W-1:0]             byte_idx;
  logic [15:0]                   count;
  logic [7:0]                    byte_arr [NUM_BYTES];
  logic [7:0]                    field_byte;
  logic                          take_snapshot;
  logic                          gap_load;
  logic                          gap_zero;

  // --------------------------------------------------------------------------
  // Snapshot bytes laid out in transmission order: field i, MSB byte first.
  // Bits above FIELD_W in a field's top byte are zero.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
      logic [BPF*8-1:0] padded;

      always_comb begin
        padded              = '0;
        padded[FIELD_W-1:0] = snapshot[i*FIELD_W +: FIELD_W];
      end

      for (genvar b = 0; b < BPF; b++) begin : g_byte
        assign byte_arr[i*BPF + (BPF - 1 - b)] = padded[b*8 +: 8];
      end
    end
  endgenerate

  always_comb begin
    int sel;
    sel        = int'(field_idx) * BPF + (BPF - 1) - int'(byte_idx);
    field_byte = 8'h00;
    if (sel >= 0 && sel < NUM_BYTES) begin
      field_byte = byte_arr[PTR_W'(sel)];
    end
  end

`ifdef TELEMETRY_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      csum <= 8'h00;
    end else if (state == S_HDR) begin
      csum <= 8'h00;
    end else if (state == S_FIELD && tx_ready) begin
      csum <= csum ^ field_byte;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    frame_done    = 1'b0;
    take_snapshot = 1'b0;
    gap_load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          take_snapshot = 1'b1;
          state_nxt     = S_HDR;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) begin
          state_nxt = S_FIELD;
        end
      end
      S_FIELD: begin
        tx_valid = 1'b1;
        tx_data  = field_byte;
        if (tx_ready && field_idx == LAST_FIELD && byte_idx == '0) begin
`ifdef TELEMETRY_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_FTR;
`endif
        end
      end
`ifdef TELEMETRY_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) begin
          state_nxt = S_FTR;
        end
      end
`endif
      S_FTR: begin
        tx_valid = 1'b1;
        tx_data  = FOOTER;
        if (tx_ready) begin
          frame_done = 1'b1;
          gap_load   = 1'b1;
          state_nxt  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_zero) begin
          if (enable) begin
            take_snapshot = 1'b1;
            state_nxt     = S_HDR;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: snapshot, byte walk counters, frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      snapshot  <= '0;
      field_idx <= '0;
      byte_idx  <= '0;
      count     <= 16'h0000;
    end else begin
      if (take_snapshot) begin
        snapshot <= fields;
      end
      if (state == S_HDR && tx_ready) begin
        field_idx <= '0;
        byte_idx  <= TOP_BYTE;
      end
      if (state == S_FIELD && tx_ready) begin
        if (byte_idx == '0) begin
          byte_idx  <= TOP_BYTE;
          field_idx <= field_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx - 1'b1;
        end
      end
      if (frame_done) begin
        count <= count + 16'd1;
      end
    end
  end

  frame_gap_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (gap_load),
    .value (GAP_LOAD),
    .zero  (gap_zero)
  );

  assign frame_count = count;
  assign busy        = (state != S_IDLE);

endmodule
`default_nettype wire
